// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128/192/256 encryption datapath, LANES columns per cycle.
// Round 0 AddRoundKey is folded into the accept; each later round spans BEATS cycles.
module aes_round_engine #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    input  logic [1:0]   mode_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         busy_o
);
    localparam int BEATS = 4 / LANES;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("aes_round_engine: LANES must be 1, 2 or 4");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Row 0 of the column sits in the top byte of the word.
    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    state_e          st_q, st_d;
    logic [127:0]    state_q, state_d, acc_q, acc_d, out_q, out_d;
    logic [3:0]      round_q, round_d, nr_q, nr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [127:0]    sr, merged;
    logic            last_round, last_beat;
    logic [31:0]     lane_res [LANES];
    logic [1:0]      lane_col [LANES];

    assign sr = shift_rows(state_q);
    assign last_round = round_q == nr_q;
    assign last_beat = beat_q == BW'(BEATS-1);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] sw;
        assign lane_col[l] = 2'(int'(beat_q) * LANES + l);
        assign sw = sub_word(sr[{lane_col[l], 5'd0} +: 32]);
        assign lane_res[l] = (last_round ? sw : mix_col(sw)) ^ rk_i[{lane_col[l], 5'd0} +: 32];
    end

    always_comb begin
        merged = acc_q;
        for (int l = 0; l < LANES; l++)
            merged[{lane_col[l], 5'd0} +: 32] = lane_res[l];
    end

    always_comb begin
        st_d = st_q;
        state_d = state_q;
        acc_d = acc_q;
        out_d = out_q;
        round_d = round_q;
        beat_d = beat_q;
        nr_d = nr_q;
        case (st_q)
            IDLE: if (in_valid_i) begin
                state_d = in_data_i ^ rk_i;
                nr_d = mode_i == 2'b00 ? 4'd10 : mode_i == 2'b01 ? 4'd12 : 4'd14;
                round_d = 4'd1;
                beat_d = '0;
                st_d = RUN;
            end
            RUN: begin
                acc_d = merged;
                beat_d = last_beat ? '0 : beat_q + 1'b1;
                if (last_beat) begin
                    state_d = merged;
                    round_d = last_round ? 4'd0 : round_q + 4'd1;
                    if (last_round) begin
                        out_d = merged;
                        st_d = DONE;
                    end
                end
            end
            DONE: st_d = out_ready_i ? IDLE : DONE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= IDLE;
            state_q <= '0;
            acc_q <= '0;
            out_q <= '0;
            round_q <= '0;
            beat_q <= '0;
            nr_q <= '0;
        end else begin
            st_q <= st_d;
            state_q <= state_d;
            acc_q <= acc_d;
            out_q <= out_d;
            round_q <= round_d;
            beat_q <= beat_d;
            nr_q <= nr_d;
        end
    end

    assign in_ready_o = st_q == IDLE;
    assign busy_o = st_q != IDLE;
    assign out_valid_o = st_q == DONE;
    assign out_data_o = out_q;
    assign rk_idx_o = st_q == RUN ? round_q : 4'd0;
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: drives LANES=1, 2 and 4 engines side by side against a byte-level AES model.
module tb_aes_round_engine;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input int lanes, input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL L%0d %s: got %h expected %h", lanes, tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: inverse in GF(2^8) (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] sq = x, inv = 8'h01, b;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic int nr_of(input logic [1:0] m);
        return m == 2'b00 ? 10 : m == 2'b01 ? 12 : 14;
    endfunction

    function automatic logic [2047:0] expand(input logic [255:0] key, input logic [1:0] m);
        int nk = nr_of(m) - 6;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [2047:0] ks = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) t = sub_word_ref(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++) ks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [127:0] encrypt_ref(input logic [2047:0] ks, input int nr, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] ct;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ks[127-8*k -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_ref(s[k]);
            for (int q = 0; q < 4; q++)
                for (int c = 0; c < 4; c++) t[q+4*c] = s[q+4*((c+q)%4)];
            for (int c = 0; c < 4; c++) begin
                {a0, a1, a2, a3} = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
                if (r == nr) {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = {a0, a1, a2, a3};
                else begin
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            end
            for (int k = 0; k < 16; k++) s[k] ^= ks[r*128 + 127 - 8*k -: 8];
        end
        for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
        return ct;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = 1 << g;
        localparam int BT = 4 / L;
        logic rst_n, in_valid, in_ready, out_valid, out_ready, busy, fin;
        logic [127:0] in_data, out_data, rk;
        logic [1:0] mode;
        logic [3:0] rk_idx;
        logic [2047:0] ks;

        assign rk = ks[int'(rk_idx)*128 +: 128];

        aes_round_engine #(.LANES(L)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .mode_i(mode),
            .rk_idx_o(rk_idx), .rk_i(rk),
            .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy)
        );

        task automatic check_reset_outputs();
            check(L, "rst in_ready", in_ready, 1);
            check(L, "rst out_valid", out_valid, 0);
            check(L, "rst busy", busy, 0);
            check(L, "rst rk_idx", rk_idx, 0);
            check(L, "rst out_data", out_data, 0);
        endtask

        // abort_at != 0 pulses rst_n when that round key is requested and skips the result.
        task automatic run_block(input logic [255:0] key, input logic [1:0] m, input logic [127:0] pt,
                                 input logic [127:0] exp, input int hold, input bit disturb, input int abort_at);
            int nr = nr_of(m);
            int k = 0;
            int peak = 0;
            logic [127:0] held;
            ks = expand(key, m);
            @(negedge clk);
            in_valid = 1'b1;
            in_data = pt;
            mode = m;
            out_ready = hold == 0;
            check(L, "in_ready idle", in_ready, 1);
            check(L, "rk_idx idle", rk_idx, 0);
            @(negedge clk);
            in_valid = 1'b0;
            while (!out_valid && k < 64) begin
                check(L, "rk_idx run", rk_idx, 128'(k / BT + 1));
                check(L, "in_ready run", in_ready, 0);
                check(L, "busy run", busy, 1);
                if (int'(rk_idx) > peak) peak = int'(rk_idx);
                if (abort_at != 0 && int'(rk_idx) == abort_at) begin
                    rst_n = 1'b0;
                    in_valid = 1'b0;
                    #1 check_reset_outputs();
                    repeat (2) @(negedge clk);
                    check_reset_outputs();
                    rst_n = 1'b1;
                    return;
                end
                if (disturb) begin
                    in_valid = 1'($urandom);
                    in_data = {$urandom, $urandom, $urandom, $urandom};
                    mode = 2'($urandom);
                end
                @(negedge clk);
                k++;
            end
            in_valid = 1'b0;
            check(L, "latency", 128'(k), 128'(nr * BT));
            check(L, "rk_idx peak", 128'(peak), 128'(nr));
            check(L, "out_data", out_data, exp);
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                check(L, "hold out_valid", out_valid, 1);
                check(L, "hold out_data", out_data, held);
                check(L, "hold in_ready", in_ready, 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check(L, "post out_valid", out_valid, 0);
            check(L, "post in_ready", in_ready, 1);
            check(L, "post busy", busy, 0);
        endtask

        initial begin
            logic [255:0] key;
            logic [127:0] pt;
            logic [1:0] m;
            fin = 1'b0;
            rst_n = 1'b0;
            in_valid = 1'b0;
            in_data = '0;
            mode = 2'b00;
            out_ready = 1'b0;
            ks = expand(K128, 2'b00);
            repeat (2) @(negedge clk);
            check_reset_outputs();
            rst_n = 1'b1;
            run_block(K128, 2'b00, PT, CT128, 0, 0, 0);
            run_block(K192, 2'b01, PT, CT192, 0, 0, 0);
            run_block(K256, 2'b10, PT, CT256, 0, 0, 0);
            run_block(K256, 2'b11, PT, CT256, 0, 0, 0);
            run_block(K128, 2'b00, PT, CT128, 7, 0, 0);
            run_block(K128, 2'b00, PT, CT128, 0, 1, 0);
            run_block(K192, 2'b01, PT, CT192, 0, 0, 5);
            run_block(K192, 2'b01, PT, CT192, 0, 0, 0);
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom;
                pt = {$urandom, $urandom, $urandom, $urandom};
                m = 2'($urandom);
                run_block(key, m, pt, encrypt_ref(expand(key, m), nr_of(m), pt),
                          $urandom_range(0, 3), 1'($urandom), 0);
            end
            fin = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        check(0, "all lanes finished", {g_dut[2].fin, g_dut[1].fin, g_dut[0].fin}, 3'b111);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
